// File: rtl/seq_rx_sync.sv
// seq_rx_sync: receive-side phase tracker for the 4-bit-counter serial
// sequence generator. It hunts for the generator's count phase using a
// 6-bit sliding window, then flywheels the phase, flagging and counting
// bit errors. It drops lock after LOSS_THRESH consecutive mismatches.
// Optional feature macro: SEQ_RX_SYNC_FRAME_EN adds frame_pulse, a
// one-cycle pulse on every accepted bit whose phase is 0 while locked.
module seq_rx_sync #(
  parameter logic [15:0] PATTERN     = 16'hE6C4,
  parameter int          LOSS_THRESH = 3,
  parameter int          ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic             data_in,
  input  logic             err_clr,
  output logic             locked,
  output logic [3:0]       phase,
  output logic             bit_err,
  output logic [ERR_W-1:0] err_count
`ifdef SEQ_RX_SYNC_FRAME_EN
  ,
  output logic             frame_pulse
`endif
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0]       LOSS_T  = 4'(LOSS_THRESH);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [2:0]       FILL_FULL = 3'd6;

  state_t           state_q;
  // The oldest window bit (w[5]) is shifted out on every strobe and is
  // never needed afterwards: a match test always uses the freshly
  // assembled window, i.e. these five history bits plus data_in.
  logic [4:0]       hist_q;
  logic [2:0]       fill_q;
  logic [3:0]       miss_q;
  logic             locked_q;
  logic [3:0]       phase_q;
  logic             bit_err_q;
  logic [ERR_W-1:0] err_count_q;

  logic [5:0]       win_d;
  logic [2:0]       fill_d;
  logic [3:0]       pred_d;
  logic             mismatch_d;
  logic             drop_d;
  logic [15:0][5:0] win_tbl;
  logic [15:0]      match_vec;
  logic             match_any;
  logic [3:0]       match_k;

  // Reference windows: entry k holds {s[k-5], ..., s[k]} with s[k] at bit 0.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_win
      for (genvar gj = 0; gj < 6; gj++) begin : g_bit
        assign win_tbl[gi][gj] = PATTERN[(gi - gj + 16) % 16];
      end
      assign match_vec[gi] = (win_d == win_tbl[gi]);
    end
  endgenerate

  // Candidate window, fill progress and locked-mode prediction for this strobe.
  always_comb begin
    win_d      = {hist_q, data_in};
    fill_d     = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 3'd1;
    pred_d     = phase_q + 4'd1;
    mismatch_d = (data_in != PATTERN[pred_d]);
    drop_d     = mismatch_d && ((miss_q + 4'd1) == LOSS_T);
  end

  // Encode the matching window index; at most one entry can match.
  always_comb begin
    match_any = |match_vec;
    match_k   = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (match_vec[k]) begin
        match_k = 4'(k);
      end
    end
  end

  // Hunt/track state machine with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      hist_q      <= '0;
      fill_q      <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      phase_q     <= '0;
      bit_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      bit_err_q <= 1'b0;
      if (err_clr) begin
        err_count_q <= '0;
      end
      if (sample_en) begin
        hist_q <= win_d[4:0];
        case (state_q)
          HUNT: begin
            fill_q <= fill_d;
            if ((fill_d == FILL_FULL) && match_any) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              phase_q  <= match_k;
              miss_q   <= '0;
            end
          end
          LOCKED: begin
            phase_q <= pred_d;
            if (!mismatch_d) begin
              miss_q <= '0;
            end else begin
              bit_err_q <= 1'b1;
              // A simultaneous clear wins; the mismatch is not counted.
              if (!err_clr && (err_count_q != ERR_MAX)) begin
                err_count_q <= err_count_q + 1'b1;
              end
              if (drop_d) begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
                fill_q   <= '0;
                miss_q   <= '0;
              end else begin
                miss_q <= miss_q + 4'd1;
              end
            end
          end
          default: begin
            state_q <= HUNT;
          end
        endcase
      end
    end
  end

`ifdef SEQ_RX_SYNC_FRAME_EN
  logic frame_set;
  logic frame_q;

  // Frame start: an accepted bit lands on phase 0 and the tracker stays locked.
  always_comb begin
    frame_set = 1'b0;
    if (sample_en) begin
      if (state_q == HUNT) begin
        frame_set = (fill_d == FILL_FULL) && match_any && (match_k == 4'd0);
      end else begin
        frame_set = (pred_d == 4'd0) && !drop_d;
      end
    end
  end

  // Register the frame marker as a single-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q <= 1'b0;
    end else begin
      frame_q <= frame_set;
    end
  end

  assign frame_pulse = frame_q;
`endif

  assign locked    = locked_q;
  assign phase     = phase_q;
  assign bit_err   = bit_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_seq_rx_sync.sv
// Directed self-checking bench for seq_rx_sync (ERR_W=2 to reach saturation).
module tb_seq_rx_sync;

  localparam int ERR_W = 2;

  logic             clk;
  logic             reset;
  logic             sample_en;
  logic             data_in;
  logic             err_clr;
  logic             locked;
  logic [3:0]       phase;
  logic             bit_err;
  logic [ERR_W-1:0] err_count;
`ifdef SEQ_RX_SYNC_FRAME_EN
  logic             frame_pulse;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int gap_n    = 2;
  logic [15:0] pat_v = 16'hE6C4;

  seq_rx_sync #(
    .PATTERN    (16'hE6C4),
    .LOSS_THRESH(3),
    .ERR_W      (ERR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .data_in    (data_in),
    .err_clr    (err_clr),
    .locked     (locked),
    .phase      (phase),
    .bit_err    (bit_err),
    .err_count  (err_count)
`ifdef SEQ_RX_SYNC_FRAME_EN
    ,
    .frame_pulse(frame_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic pbit(input int i);
    return pat_v[i % 16];
  endfunction

  // One strobe spaced gap_n+1 clocks from the previous one; returns at the
  // falling edge right after the strobe edge, where its effects are visible.
  task automatic send(input logic b, input logic clr);
    repeat (gap_n) @(negedge clk);
    data_in   = b;
    sample_en = 1'b1;
    err_clr   = clr;
    @(negedge clk);
    sample_en = 1'b0;
    err_clr   = 1'b0;
    $display("strobe bit=%0b clr=%0b -> locked=%0b phase=%0d bit_err=%0b err_count=%0d",
             b, clr, locked, phase, bit_err, err_count);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b expected 0", locked); end
    n_checks++; if (phase !== 4'd0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    n_checks++; if (bit_err !== 1'b0) begin n_fail++; $display("FAIL reset_bit_err: got %0b expected 0", bit_err); end
    n_checks++; if (err_count !== 2'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_acquire_s0();
    for (int i = 0; i < 5; i++) begin
      send(pbit(i), 1'b0);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL s0_early_lock: strobe %0d got locked=%0b expected 0", i, locked); end
    end
    send(pbit(5), 1'b0);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL s0_lock: got %0b expected 1", locked); end
    n_checks++; if (phase !== 4'd5) begin n_fail++; $display("FAIL s0_phase: got %0d expected 5", phase); end
    for (int i = 6; i < 22; i++) begin
      send(pbit(i), 1'b0);
      n_checks++; if (phase !== 4'(i % 16)) begin n_fail++; $display("FAIL s0_track_phase: got %0d expected %0d", phase, i % 16); end
      n_checks++; if (bit_err !== 1'b0) begin n_fail++; $display("FAIL s0_track_bit_err: got %0b expected 0", bit_err); end
`ifdef SEQ_RX_SYNC_FRAME_EN
      n_checks++; if (frame_pulse !== (i == 16)) begin n_fail++; $display("FAIL s0_frame: got %0b expected %0b", frame_pulse, i == 16); end
`endif
    end
    n_checks++; if (err_count !== 2'd0) begin n_fail++; $display("FAIL s0_err_count: got %0d expected 0", err_count); end
  endtask

  task automatic test_single_error();
    send(~pbit(6), 1'b0);
    n_checks++; if (bit_err !== 1'b1) begin n_fail++; $display("FAIL single_bit_err: got %0b expected 1", bit_err); end
    n_checks++; if (err_count !== 2'd1) begin n_fail++; $display("FAIL single_err_count: got %0d expected 1", err_count); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL single_locked: got %0b expected 1", locked); end
    n_checks++; if (phase !== 4'd6) begin n_fail++; $display("FAIL single_phase: got %0d expected 6", phase); end
    @(negedge clk);
    n_checks++; if (bit_err !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %0b expected 0", bit_err); end
    send(pbit(7), 1'b0);
    send(pbit(8), 1'b0);
    n_checks++; if (bit_err !== 1'b0) begin n_fail++; $display("FAIL single_clean_bit_err: got %0b expected 0", bit_err); end
    n_checks++; if (phase !== 4'd8) begin n_fail++; $display("FAIL single_clean_phase: got %0d expected 8", phase); end
    n_checks++; if (err_count !== 2'd1) begin n_fail++; $display("FAIL single_clean_err_count: got %0d expected 1", err_count); end
  endtask

  task automatic test_loss_relock();
    send(~pbit(9), 1'b0);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_miss1_locked: got %0b expected 1", locked); end
    send(~pbit(10), 1'b0);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_miss2_locked: got %0b expected 1", locked); end
    n_checks++; if (err_count !== 2'd3) begin n_fail++; $display("FAIL loss_miss2_err_count: got %0d expected 3", err_count); end
    send(~pbit(11), 1'b0);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL loss_drop: got %0b expected 0", locked); end
    n_checks++; if (err_count !== 2'd3) begin n_fail++; $display("FAIL loss_saturate: got %0d expected 3", err_count); end
    for (int i = 12; i < 17; i++) begin
      send(pbit(i), 1'b0);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early: got %0b expected 0", locked); end
    end
    send(pbit(1), 1'b0);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock_locked: got %0b expected 1", locked); end
    n_checks++; if (phase !== 4'd1) begin n_fail++; $display("FAIL relock_phase: got %0d expected 1", phase); end
  endtask

  task automatic test_err_clr();
    send(~pbit(2), 1'b1);
    n_checks++; if (bit_err !== 1'b1) begin n_fail++; $display("FAIL clr_bit_err: got %0b expected 1", bit_err); end
    n_checks++; if (err_count !== 2'd0) begin n_fail++; $display("FAIL clr_priority: got %0d expected 0", err_count); end
    for (int j = 0; j < 5; j++) begin
      send(~pbit(3 + 2 * j), 1'b0);
      n_checks++; if (err_count !== ((j < 2) ? 2'(j + 1) : 2'd3)) begin n_fail++; $display("FAIL sat_err_count: got %0d expected %0d", err_count, (j < 2) ? j + 1 : 3); end
      send(pbit(4 + 2 * j), 1'b0);
    end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL sat_locked: got %0b expected 1", locked); end
    n_checks++; if (phase !== 4'd12) begin n_fail++; $display("FAIL sat_phase: got %0d expected 12", phase); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++; if (err_count !== 2'd0) begin n_fail++; $display("FAIL clr_alone: got %0d expected 0", err_count); end
  endtask

  task automatic test_gap();
    repeat (25) @(negedge clk);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL gap_locked: got %0b expected 1", locked); end
    n_checks++; if (phase !== 4'd12) begin n_fail++; $display("FAIL gap_phase: got %0d expected 12", phase); end
    gap_n = 9;
    send(pbit(13), 1'b0);
    gap_n = 2;
    n_checks++; if (phase !== 4'd13) begin n_fail++; $display("FAIL gap_resume_phase: got %0d expected 13", phase); end
  endtask

  task automatic test_reset_midlock();
    send(~pbit(14), 1'b0);
    n_checks++; if (err_count !== 2'd1) begin n_fail++; $display("FAIL midlock_pre_err: got %0d expected 1", err_count); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL midlock_locked: got %0b expected 0", locked); end
    n_checks++; if (phase !== 4'd0) begin n_fail++; $display("FAIL midlock_phase: got %0d expected 0", phase); end
    n_checks++; if (err_count !== 2'd0) begin n_fail++; $display("FAIL midlock_err_count: got %0d expected 0", err_count); end
    n_checks++; if (bit_err !== 1'b0) begin n_fail++; $display("FAIL midlock_bit_err: got %0b expected 0", bit_err); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_acquire_s9();
    logic [5:0] seq;
    seq = 6'b110011;
    for (int i = 5; i >= 0; i--) begin
      send(seq[i], 1'b0);
      if (i == 1) begin
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL s9_early: got %0b expected 0", locked); end
      end
    end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL s9_locked: got %0b expected 1", locked); end
    n_checks++; if (phase !== 4'd14) begin n_fail++; $display("FAIL s9_phase: got %0d expected 14", phase); end
  endtask

  task automatic test_acquire_s14();
    logic [5:0] seq;
    do_reset();
    seq = 6'b110010;
    for (int i = 5; i >= 0; i--) begin
      send(seq[i], 1'b0);
    end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL s14_locked: got %0b expected 1", locked); end
    n_checks++; if (phase !== 4'd3) begin n_fail++; $display("FAIL s14_phase: got %0d expected 3", phase); end
  endtask

  task automatic test_hunt_slide();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 1'b0);
    end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL slide_invalid: got %0b expected 0", locked); end
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL slide_partial: got %0b expected 0", locked); end
    send(1'b1, 1'b0);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL slide_locked: got %0b expected 1", locked); end
    n_checks++; if (phase !== 4'd2) begin n_fail++; $display("FAIL slide_phase: got %0d expected 2", phase); end
    n_checks++; if (err_count !== 2'd0) begin n_fail++; $display("FAIL slide_err_count: got %0d expected 0", err_count); end
  endtask

  initial begin
    reset     = 1'b1;
    sample_en = 1'b0;
    data_in   = 1'b0;
    err_clr   = 1'b0;
    test_reset();
    test_acquire_s0();
    test_single_error();
    test_loss_relock();
    test_err_clr();
    test_gap();
    test_reset_midlock();
    test_acquire_s9();
    test_acquire_s14();
    test_hunt_slide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
